// File: rtl/idct_accum.sv
// IDCT output accumulator: sums TERMS signed products, rounds, shifts by SHIFT,
// saturates to 9-bit signed and holds the sample until the consumer takes it.
module idct_accum #(
  parameter int unsigned TERMS = 8,
  parameter int unsigned SHIFT = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [8:0]        out_data,
  input  logic              out_ready
);

  localparam int unsigned DW    = 16;
  localparam int unsigned OW    = 9;
  localparam int unsigned ACC_W = DW + $clog2(TERMS);
  localparam int unsigned CNT_W = $clog2(TERMS + 1);
  localparam int unsigned SW    = ACC_W + 1;

  localparam logic signed [SW-1:0] MAXV = SW'((2 ** (OW - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = -SW'(2 ** (OW - 1));
  localparam logic signed [SW-1:0] RND  = SW'(2 ** (SHIFT - 1));

  typedef enum logic {ACC, HOLD} state_t;

  state_t                   r_state;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_out_valid;
  logic [OW-1:0]            r_out_data;

  logic signed [ACC_W-1:0]  w_term;
  logic signed [ACC_W-1:0]  w_acc_nxt;
  logic signed [SW-1:0]     w_rnd;
  logic signed [SW-1:0]     w_shr;
  logic [OW-1:0]            w_sat;
  logic                     w_last;

  assign in_ready  = (r_state == ACC);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign w_last    = (r_cnt == CNT_W'(TERMS - 1));

  // Running sum including the current term, then round/shift/saturate at full precision
  always_comb begin
    w_term    = {{(ACC_W - DW){in_data[DW-1]}}, in_data};
    w_acc_nxt = r_acc + w_term;
    w_rnd     = {w_acc_nxt[ACC_W-1], w_acc_nxt} + RND;
    w_shr     = w_rnd >>> SHIFT;
    if (w_shr > MAXV) begin
      w_sat = {1'b0, {(OW - 1){1'b1}}};
    end else if (w_shr < MINV) begin
      w_sat = {1'b1, {(OW - 1){1'b0}}};
    end else begin
      w_sat = w_shr[OW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        ACC: begin
          // clr beats a coincident term
          if (clr) begin
            r_acc <= '0;
            r_cnt <= '0;
          end else if (in_valid) begin
            if (w_last) begin
              r_out_data  <= w_sat;
              r_out_valid <= 1'b1;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_state     <= HOLD;
            end else begin
              r_acc <= w_acc_nxt;
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ACC;
          end
        end
        default: r_state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_idct_accum.sv
// Directed bench for idct_accum: hand-computed sums covering latency, rounding,
// saturation, backpressure, clr and async reset.
module tb_idct_accum;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [8:0]  out_data;
  logic        out_ready;

  int n_cmp;
  int n_err;

  idct_accum #(.TERMS(8), .SHIFT(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sdata();
    logic signed [8:0] v;
    v = out_data;
    return int'(v);
  endfunction

  // Present v for n consecutive cycles, then drop in_valid
  task automatic feed_n(input int n, input logic [15:0] v);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = v;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Check the presented result, then let out_ready consume it
  task automatic take_sample(input string tag, input int exp);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_data"}, sdata(), exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", sdata(), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    #2;

    // Basic: 8 x 128 -> 8, single-cycle HOLD
    @(posedge clk);
    #1;
    feed_n(8, 16'd128);
    chk("basic_valid", int'(out_valid), 1);
    chk("basic_data", sdata(), 8);
    chk("basic_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("basic_drop_valid", int'(out_valid), 0);
    chk("basic_ready_back", int'(in_ready), 1);

    // Rounding boundaries
    feed_n(7, 16'd0); feed_n(1, 16'd63);
    take_sample("rnd63", 0);
    feed_n(7, 16'd0); feed_n(1, 16'd64);
    take_sample("rnd64", 1);
    feed_n(7, 16'd0); feed_n(1, 16'hFFC0);
    take_sample("rndm64", 0);
    feed_n(7, 16'd0); feed_n(1, 16'hFFBF);
    take_sample("rndm65", -1);

    // Saturation both ends
    feed_n(8, 16'h7FFF);
    take_sample("sat_pos", 255);
    feed_n(8, 16'h8000);
    take_sample("sat_neg", -256);

    // Backpressure: 8 x 640 -> 40, held 5 cycles with in_valid busy
    out_ready = 1'b0;
    feed_n(8, 16'd640);
    in_valid = 1'b1;
    in_data  = 16'd1000;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_data", sdata(), 40);
      chk("bp_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_ready", int'(in_ready), 1);
    feed_n(8, 16'd16);
    take_sample("bp_fresh", 1);

    // clr wins over a coincident term
    feed_n(3, 16'd1000);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd500;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    chk("clr_no_valid", int'(out_valid), 0);
    feed_n(8, 16'd16);
    take_sample("clr_sum", 1);

    // Async reset mid-accumulation
    feed_n(5, 16'd256);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", int'(out_valid), 0);
    chk("rst_mid_data", sdata(), 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    feed_n(8, 16'd256);
    take_sample("after_rst_mid", 16);

    // Async reset while holding a result
    out_ready = 1'b0;
    feed_n(8, 16'd256);
    chk("hold_pre_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", int'(out_valid), 0);
    chk("rst_hold_data", sdata(), 0);
    chk("rst_hold_ready", int'(in_ready), 1);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    feed_n(8, 16'd256);
    take_sample("after_rst_hold", 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
